// File: rtl/audio_source_scheduler.sv
`default_nettype none
// ==== audio_source_scheduler : fixed-priority stereo source scheduler with gain-ramped switching ====
// ==== rev 1.0 : fade ramps are built only when AUDIO_SWITCH_FADE_EN is defined                  ====
module audio_source_scheduler #(
  parameter int AUDIO_BIT_WIDTH = 16,
  parameter int NUM_SRC         = 4,
  parameter int RAMP_LOG2       = 6
) (
  input  logic                                 clk_audio,
  input  logic                                 reset,
  input  logic [NUM_SRC-1:0]                   i_src_req,
  input  logic [NUM_SRC*2*AUDIO_BIT_WIDTH-1:0] i_src_sample,
  input  logic                                 i_mute,
  output logic [NUM_SRC-1:0]                   o_src_ack,
  output logic [NUM_SRC-1:0]                   o_grant,
  output logic [RAMP_LOG2:0]                   o_gain,
  output logic                                 o_active,
  output logic [AUDIO_BIT_WIDTH-1:0]           o_audio_sample_word_l,
  output logic [AUDIO_BIT_WIDTH-1:0]           o_audio_sample_word_r
);

  localparam int W    = AUDIO_BIT_WIDTH;
  localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PW   = W + RAMP_LOG2 + 2;
  localparam logic [RAMP_LOG2:0] GAIN_FULL = {1'b1, {RAMP_LOG2{1'b0}}};
`ifdef AUDIO_SWITCH_FADE_EN
  localparam logic [RAMP_LOG2:0] GAIN_ONE  = {{RAMP_LOG2{1'b0}}, 1'b1};
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_IN  = 2'd1,
    S_PLAY     = 2'd2,
    S_FADE_OUT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [RAMP_LOG2:0] r_gain;
  logic [RAMP_LOG2:0] w_gain_nxt;
  logic [IDXW-1:0]    r_owner;
  logic [IDXW-1:0]    w_owner_nxt;
  logic [NUM_SRC-1:0] r_grant;
  logic [NUM_SRC-1:0] w_grant_nxt;

  logic               w_req_any;
  logic [IDXW-1:0]    w_req_idx;
  logic               w_owner_req;
  logic               w_preempt;
  logic               w_exit;
  logic               w_cap_en;
  logic [W-1:0]       w_sel_l;
  logic [W-1:0]       w_sel_r;

  logic signed [W-1:0]  r_cap_l;
  logic signed [W-1:0]  r_cap_r;
  logic [RAMP_LOG2:0]   r_gain_cap;
  logic [NUM_SRC-1:0]   r_cap_own;
  logic [NUM_SRC-1:0]   r_ack;
  logic [W-1:0]         r_out_l;
  logic [W-1:0]         r_out_r;
  logic signed [PW-1:0] w_gain_s;
  logic signed [PW-1:0] w_cap_ext_l;
  logic signed [PW-1:0] w_cap_ext_r;
  logic signed [PW-1:0] w_prod_l;
  logic signed [PW-1:0] w_prod_r;
  logic [W-1:0]         w_scaled_l;
  logic [W-1:0]         w_scaled_r;

  // Lowest set request index wins arbitration.
  always_comb begin
    w_req_any = |i_src_req;
    w_req_idx = '0;
    for (int s = NUM_SRC - 1; s >= 0; s--) begin
      if (i_src_req[s]) w_req_idx = IDXW'(s);
    end
  end

  always_comb begin
    w_sel_l     = '0;
    w_sel_r     = '0;
    w_owner_req = 1'b0;
    w_preempt   = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (IDXW'(s) == r_owner) begin
        w_sel_l     = i_src_sample[(2*s)*W +: W];
        w_sel_r     = i_src_sample[(2*s+1)*W +: W];
        w_owner_req = i_src_req[s];
      end
      if ((IDXW'(s) < r_owner) && i_src_req[s]) w_preempt = 1'b1;
    end
  end

  assign w_exit   = !w_owner_req || i_mute || w_preempt;
  assign w_cap_en = (r_state != S_IDLE) && w_owner_req;

  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    w_owner_nxt = r_owner;
    case (r_state)
      S_IDLE: begin
        w_gain_nxt = '0;
        if (w_req_any && !i_mute) begin
          w_owner_nxt = w_req_idx;
`ifdef AUDIO_SWITCH_FADE_EN
          w_state_nxt = S_FADE_IN;
`else
          w_state_nxt = S_PLAY;
          w_gain_nxt  = GAIN_FULL;
`endif
        end
      end
`ifdef AUDIO_SWITCH_FADE_EN
      S_FADE_IN: begin
        if (w_exit) begin
          w_state_nxt = S_FADE_OUT;
        end else if (r_gain == (GAIN_FULL - GAIN_ONE)) begin
          w_state_nxt = S_PLAY;
          w_gain_nxt  = GAIN_FULL;
        end else begin
          w_gain_nxt = r_gain + GAIN_ONE;
        end
      end
      S_PLAY: begin
        w_gain_nxt = GAIN_FULL;
        if (w_exit) w_state_nxt = S_FADE_OUT;
      end
      // A fade entered at gain 0 (exit right after grant) ends immediately.
      S_FADE_OUT: begin
        if (r_gain <= GAIN_ONE) begin
          w_state_nxt = S_IDLE;
          w_gain_nxt  = '0;
        end else begin
          w_gain_nxt = r_gain - GAIN_ONE;
        end
      end
`else
      S_PLAY: begin
        w_gain_nxt = GAIN_FULL;
        if (w_exit) begin
          w_state_nxt = S_IDLE;
          w_gain_nxt  = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_gain_nxt  = '0;
      end
    endcase
    w_grant_nxt = (w_state_nxt == S_IDLE) ? '0 : (NUM_SRC'(1) << w_owner_nxt);
  end

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gain  <= '0;
      r_owner <= '0;
      r_grant <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
      r_owner <= w_owner_nxt;
      r_grant <= w_grant_nxt;
    end
  end

  // Capture stage pairs the sample with the gain current at that edge.
  assign w_gain_s    = {{(PW-RAMP_LOG2-1){1'b0}}, r_gain_cap};
  assign w_cap_ext_l = {{(PW-W){r_cap_l[W-1]}}, r_cap_l};
  assign w_cap_ext_r = {{(PW-W){r_cap_r[W-1]}}, r_cap_r};
  assign w_prod_l    = w_cap_ext_l * w_gain_s;
  assign w_prod_r    = w_cap_ext_r * w_gain_s;
  assign w_scaled_l  = W'(w_prod_l >>> RAMP_LOG2);
  assign w_scaled_r  = W'(w_prod_r >>> RAMP_LOG2);

  always_ff @(posedge clk_audio) begin
    if (reset) begin
      r_cap_l    <= '0;
      r_cap_r    <= '0;
      r_gain_cap <= '0;
      r_cap_own  <= '0;
      r_ack      <= '0;
      r_out_l    <= '0;
      r_out_r    <= '0;
    end else begin
      if (w_cap_en) begin
        r_cap_l <= w_sel_l;
        r_cap_r <= w_sel_r;
      end
      r_cap_own  <= w_cap_en ? r_grant : '0;
      r_ack      <= r_cap_own;
      r_gain_cap <= r_gain;
      r_out_l    <= w_scaled_l;
      r_out_r    <= w_scaled_r;
    end
  end

  assign o_src_ack             = r_ack;
  assign o_grant               = r_grant;
  assign o_gain                = r_gain;
  assign o_active              = (r_state != S_IDLE);
  assign o_audio_sample_word_l = r_out_l;
  assign o_audio_sample_word_r = r_out_r;

endmodule
`default_nettype wire

// File: tb/tb_audio_source_scheduler.sv
`default_nettype none
// tb_audio_source_scheduler: scenario and randomized tests against a behavioural scheduler model.
module tb_audio_source_scheduler;

  localparam int W  = 16;
  localparam int NS = 4;
  localparam int R  = 2;
  localparam int D  = 4;
`ifdef AUDIO_SWITCH_FADE_EN
  localparam bit FADE     = 1'b1;
  localparam int PRE_IDLE = 4;
  localparam int G4_IDX   = 6;
`else
  localparam bit FADE     = 1'b0;
  localparam int PRE_IDLE = 0;
  localparam int G4_IDX   = 2;
`endif

  logic            clk_audio = 1'b0;
  logic            reset     = 1'b1;
  logic [NS-1:0]   src_req   = '0;
  logic [NS*2*W-1:0] src_sample = '0;
  logic            mute      = 1'b0;
  logic [NS-1:0]   src_ack;
  logic [NS-1:0]   grant;
  logic [R:0]      gain;
  logic            active;
  logic [W-1:0]    out_l;
  logic [W-1:0]    out_r;

  logic [W-1:0] smp_l [NS];
  logic [W-1:0] smp_r [NS];

  int n_checks = 0;
  int n_errors = 0;

  int            m_mode;
  int            m_gain;
  int            m_owner;
  int            m_cap_l;
  int            m_cap_r;
  int            m_gcap;
  logic [NS-1:0] m_capown;
  logic [NS-1:0] m_ack;
  logic [NS-1:0] m_grant;
  logic [R:0]    m_gain_v;
  logic          m_active;
  logic [W-1:0]  m_out_l;
  logic [W-1:0]  m_out_r;

  audio_source_scheduler #(
    .AUDIO_BIT_WIDTH(W),
    .NUM_SRC        (NS),
    .RAMP_LOG2      (R)
  ) dut (
    .clk_audio            (clk_audio),
    .reset                (reset),
    .i_src_req            (src_req),
    .i_src_sample         (src_sample),
    .i_mute               (mute),
    .o_src_ack            (src_ack),
    .o_grant              (grant),
    .o_gain               (gain),
    .o_active             (active),
    .o_audio_sample_word_l(out_l),
    .o_audio_sample_word_r(out_r)
  );

  always #5 clk_audio = ~clk_audio;

  // floor(c*g / 2^R)
  function automatic logic [W-1:0] fscale(int c, int g);
    int p;
    int q;
    p = c * g;
    if (p >= 0) q = p / D;
    else        q = -((-p + D - 1) / D);
    return q[W-1:0];
  endfunction

  // Modes: 0 idle, 1 ramping up, 2 full, 3 ramping down.
  task automatic model_step();
    int lo;
    bit ex;
    if (reset) begin
      m_mode = 0; m_gain = 0; m_owner = 0; m_cap_l = 0; m_cap_r = 0; m_gcap = 0;
      m_capown = '0; m_ack = '0; m_out_l = '0; m_out_r = '0;
    end else begin
      m_ack   = m_capown;
      m_out_l = fscale(m_cap_l, m_gcap);
      m_out_r = fscale(m_cap_r, m_gcap);
      m_gcap  = m_gain;
      m_capown = '0;
      if (m_mode != 0 && src_req[m_owner]) begin
        m_cap_l = int'($signed(smp_l[m_owner]));
        m_cap_r = int'($signed(smp_r[m_owner]));
        m_capown[m_owner] = 1'b1;
      end
      lo = -1;
      for (int s = NS - 1; s >= 0; s--) if (src_req[s]) lo = s;
      ex = mute || !src_req[m_owner] || (lo >= 0 && lo < m_owner);
      case (m_mode)
        0: if (lo >= 0 && !mute) begin
             m_owner = lo;
             m_mode  = FADE ? 1 : 2;
             m_gain  = FADE ? 0 : D;
           end
        1: if (ex) m_mode = 3;
           else begin
             m_gain++;
             if (m_gain == D) m_mode = 2;
           end
        2: if (ex) begin
             if (FADE) m_mode = 3;
             else begin m_mode = 0; m_gain = 0; end
           end
        default: begin
          if (m_gain > 0) m_gain--;
          if (m_gain == 0) m_mode = 0;
        end
      endcase
    end
    m_grant = '0;
    if (m_mode != 0) m_grant[m_owner] = 1'b1;
    m_active = (m_mode != 0);
    m_gain_v = m_gain[R:0];
  endtask

  task automatic tick();
    for (int s = 0; s < NS; s++) begin
      src_sample[(2*s)*W +: W]   = smp_l[s];
      src_sample[(2*s+1)*W +: W] = smp_r[s];
    end
    @(posedge clk_audio);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; src_req = 4'b1111; mute = 1'b0;
    tick(); tick();
    n_checks++; if (grant !== 4'b0000) begin n_errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    n_checks++; if (gain !== 3'd0) begin n_errors++; $display("FAIL reset_gain got %0d want 0", gain); end
    n_checks++; if (active !== 1'b0) begin n_errors++; $display("FAIL reset_active got %b want 0", active); end
    n_checks++; if (src_ack !== 4'b0000) begin n_errors++; $display("FAIL reset_ack got %b want 0000", src_ack); end
    n_checks++; if (out_l !== 16'h0000 || out_r !== 16'h0000) begin
      n_errors++; $display("FAIL reset_out got %h/%h want 0000/0000", out_l, out_r);
    end
    reset = 1'b0; src_req = '0;
  endtask

  task automatic test_fade_in();
`ifdef AUDIO_SWITCH_FADE_EN
    logic [W-1:0] exp_o [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h4000};
    int           exp_g [8] = '{0, 1, 2, 3, 4, 4, 4, 4};
`else
    logic [W-1:0] exp_o [8] = '{16'h0000, 16'h0000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
    int           exp_g [8] = '{4, 4, 4, 4, 4, 4, 4, 4};
`endif
    logic [NS-1:0] exp_a;
    do_reset();
    smp_l[0] = 16'h4000; smp_r[0] = 16'h4000;
    src_req = 4'b0001;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp_a = (e >= 2) ? 4'b0001 : 4'b0000;
      n_checks++; if (out_l !== exp_o[e] || out_r !== exp_o[e]) begin
        n_errors++; $display("FAIL fade_in_out[%0d] got %h/%h want %h", e, out_l, out_r, exp_o[e]);
      end
      n_checks++; if (int'(gain) != exp_g[e] || grant !== 4'b0001) begin
        n_errors++; $display("FAIL fade_in_gain[%0d] got %0d/%b want %0d/0001", e, gain, grant, exp_g[e]);
      end
      n_checks++; if (src_ack !== exp_a) begin
        n_errors++; $display("FAIL fade_in_ack[%0d] got %b want %b", e, src_ack, exp_a);
      end
    end
  endtask

  // Continues from the full-gain state left by test_fade_in.
  task automatic test_release();
`ifdef AUDIO_SWITCH_FADE_EN
    logic [W-1:0]  exp_o [8] = '{16'h4000, 16'h4000, 16'h4000, 16'h3000, 16'h2000, 16'h1000, 16'h0000, 16'h0000};
    logic [NS-1:0] exp_gr [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`else
    logic [W-1:0]  exp_o [8] = '{16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    logic [NS-1:0] exp_gr [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
    logic [NS-1:0] exp_a;
    src_req = 4'b0000;
    smp_l[0] = 16'h1234; smp_r[0] = 16'h5678;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp_a = (e == 0) ? 4'b0001 : 4'b0000;
      n_checks++; if (out_l !== exp_o[e] || out_r !== exp_o[e]) begin
        n_errors++; $display("FAIL release_out[%0d] got %h/%h want %h", e, out_l, out_r, exp_o[e]);
      end
      n_checks++; if (grant !== exp_gr[e] || src_ack !== exp_a) begin
        n_errors++; $display("FAIL release_grant_ack[%0d] got %b/%b want %b/%b", e, grant, src_ack, exp_gr[e], exp_a);
      end
    end
  endtask

  task automatic test_rounding();
    logic [W-1:0] ol [8];
    logic [W-1:0] orr [8];
    do_reset();
    smp_l[0] = 16'h8001; smp_r[0] = 16'h7FFF;
    src_req = 4'b0001;
    for (int e = 0; e < 8; e++) begin
      tick();
      ol[e] = out_l; orr[e] = out_r;
      n_checks++; if (out_l !== m_out_l || out_r !== m_out_r) begin
        n_errors++; $display("FAIL rounding_model[%0d] got %h/%h want %h/%h", e, out_l, out_r, m_out_l, m_out_r);
      end
    end
`ifdef AUDIO_SWITCH_FADE_EN
    n_checks++; if (ol[3] !== 16'hE000 || orr[3] !== 16'h1FFF) begin
      n_errors++; $display("FAIL rounding_gain1 got %h/%h want e000/1fff", ol[3], orr[3]);
    end
`endif
    n_checks++; if (ol[G4_IDX] !== 16'h8001 || orr[G4_IDX] !== 16'h7FFF) begin
      n_errors++; $display("FAIL rounding_gain4 got %h/%h want 8001/7fff", ol[G4_IDX], orr[G4_IDX]);
    end
  endtask

  task automatic test_preempt();
    logic [NS-1:0] g [12];
    int zeros;
    do_reset();
    for (int s = 0; s < NS; s++) begin smp_l[s] = W'($urandom); smp_r[s] = W'($urandom); end
    src_req = 4'b0100;
    repeat (6) tick();
    n_checks++; if (grant !== 4'b0100 || gain !== 3'd4) begin
      n_errors++; $display("FAIL preempt_setup got %b/%0d want 0100/4", grant, gain);
    end
    src_req = 4'b0110;
    zeros = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      g[e] = grant;
      if (grant == 4'b0000) zeros++;
      n_checks++; if (grant !== m_grant || gain !== m_gain_v || out_l !== m_out_l) begin
        n_errors++; $display("FAIL preempt_model[%0d] got %b/%0d/%h want %b/%0d/%h", e, grant, gain, out_l, m_grant, m_gain_v, m_out_l);
      end
    end
    n_checks++; if (zeros != 1) begin n_errors++; $display("FAIL preempt_idle_cycles got %0d want 1", zeros); end
    n_checks++; if (g[PRE_IDLE] !== 4'b0000 || g[PRE_IDLE+1] !== 4'b0010 || g[11] !== 4'b0010) begin
      n_errors++; $display("FAIL preempt_regrant got %b,%b,%b want 0000,0010,0010", g[PRE_IDLE], g[PRE_IDLE+1], g[11]);
    end
    do_reset();
    src_req = 4'b0100;
    repeat (6) tick();
    src_req = 4'b1100;
    for (int e = 0; e < 10; e++) begin
      tick();
      n_checks++; if (grant !== 4'b0100 || gain !== 3'd4) begin
        n_errors++; $display("FAIL lower_prio_no_preempt[%0d] got %b/%0d want 0100/4", e, grant, gain);
      end
    end
  endtask

  task automatic test_mute();
    do_reset();
    smp_l[0] = 16'h2222; smp_r[0] = 16'hDDDD;
    src_req = 4'b0001;
    repeat (3) tick();
    mute = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++; if (gain !== m_gain_v || active !== m_active || grant !== m_grant) begin
        n_errors++; $display("FAIL mute_fade[%0d] got %0d/%b/%b want %0d/%b/%b", e, gain, active, grant, m_gain_v, m_active, m_grant);
      end
    end
    n_checks++; if (gain !== 3'd0 || active !== 1'b0) begin
      n_errors++; $display("FAIL mute_settled got %0d/%b want 0/0", gain, active);
    end
    src_req = 4'b1111;
    for (int e = 0; e < 8; e++) begin
      tick();
      n_checks++; if (grant !== 4'b0000 || active !== 1'b0) begin
        n_errors++; $display("FAIL mute_blocks_grant[%0d] got %b/%b want 0000/0", e, grant, active);
      end
    end
    mute = 1'b0;
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_errors++; $display("FAIL unmute_grant got %b want 0001", grant); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    smp_l[0] = 16'h4000; smp_r[0] = 16'h4000;
    src_req = 4'b0001;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    n_checks++; if (grant !== 4'b0000 || gain !== 3'd0 || active !== 1'b0 || src_ack !== 4'b0000) begin
      n_errors++; $display("FAIL reset_mid_ctrl got %b/%0d/%b/%b want 0000/0/0/0000", grant, gain, active, src_ack);
    end
    n_checks++; if (out_l !== 16'h0000 || out_r !== 16'h0000) begin
      n_errors++; $display("FAIL reset_mid_out got %h/%h want 0000/0000", out_l, out_r);
    end
    reset = 1'b0;
    tick();
    n_checks++; if (grant !== 4'b0001) begin n_errors++; $display("FAIL reset_mid_regrant got %b want 0001", grant); end
  endtask

  task automatic test_random();
    do_reset();
    src_req = '0; mute = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int s = 0; s < NS; s++) begin
        if ($urandom_range(15) == 0) src_req[s] = ~src_req[s];
        if ($urandom_range(3) == 0) begin smp_l[s] = W'($urandom); smp_r[s] = W'($urandom); end
      end
      if ($urandom_range(39) == 0) mute = ~mute;
      reset = ($urandom_range(299) == 0);
      tick();
      n_checks++; if (grant !== m_grant) begin n_errors++; $display("FAIL rand_grant[%0d] got %b want %b", c, grant, m_grant); end
      n_checks++; if (gain !== m_gain_v) begin n_errors++; $display("FAIL rand_gain[%0d] got %0d want %0d", c, gain, m_gain_v); end
      n_checks++; if (active !== m_active) begin n_errors++; $display("FAIL rand_active[%0d] got %b want %b", c, active, m_active); end
      n_checks++; if (src_ack !== m_ack) begin n_errors++; $display("FAIL rand_ack[%0d] got %b want %b", c, src_ack, m_ack); end
      n_checks++; if (out_l !== m_out_l) begin n_errors++; $display("FAIL rand_out_l[%0d] got %h want %h", c, out_l, m_out_l); end
      n_checks++; if (out_r !== m_out_r) begin n_errors++; $display("FAIL rand_out_r[%0d] got %h want %h", c, out_r, m_out_r); end
    end
    reset = 1'b0; mute = 1'b0; src_req = '0;
  endtask

  initial begin
    for (int s = 0; s < NS; s++) begin smp_l[s] = '0; smp_r[s] = '0; end
    test_reset();
    test_fade_in();
    test_release();
    test_rounding();
    test_preempt();
    test_mute();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
